// File: rtl/key_filter_multi_if.sv
// key_filter_multi_if
//   Groups the key-side signals of the multi-channel key filter.
//   master : the board / testbench side, drives raw keys and repeat enables
//   slave  : the filter, returns the debounced level and the event pulses
//   Signals (all KEY_NUM wide):
//     key_in      raw keys, active-low, asynchronous to sys_clk
//     rpt_en      per-channel auto-repeat enable, synchronous
//     key_level   debounced state, 1 = pressed
//     key_flag    one-cycle pulse on debounced press and on each auto-repeat
//     key_release one-cycle pulse on debounced release
interface key_filter_multi_if #(
  parameter int KEY_NUM = 4
);
  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] rpt_en;
  logic [KEY_NUM-1:0] key_level;
  logic [KEY_NUM-1:0] key_flag;
  logic [KEY_NUM-1:0] key_release;

  modport master (
    output key_in,
    output rpt_en,
    input  key_level,
    input  key_flag,
    input  key_release
  );

  modport slave (
    input  key_in,
    input  rpt_en,
    output key_level,
    output key_flag,
    output key_release
  );
endinterface

// File: rtl/key_filter_multi.sv
// key_filter_multi
//   Multi-channel key debouncer with press / release pulses and auto-repeat.
//   Each active-low key is synchronised (2 flops), debounced over CNT_MAX+1
//   stable clocks and tracked by its own state machine.
//   Ports:
//     sys_clk    system clock (50 MHz)
//     sys_rst_n  asynchronous active-low reset
//     kif        key_filter_multi_if.slave (key_in, rpt_en in;
//                key_level, key_flag, key_release out)
//   Optional feature macro: KEY_FILTER_RELEASE_EN
//     defined     -> key_release pulses on each debounced release
//     not defined -> key_release tied to 0 (release still debounces key_level)
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | key released and stable, key_level = 0
//   PRESS_DB   | key seen pressed, waiting for CNT_MAX+1 stable clocks
//   HELD       | key pressed and stable, auto-repeat timer may run
//   RELEASE_DB | key seen released, waiting for CNT_MAX+1 stable clocks
module key_filter_multi #(
  parameter int KEY_NUM  = 4,
  parameter int CNT_MAX  = 999_999,
  parameter int CNT_W    = 20,
  parameter int HOLD_MAX = 24_999_999,
  parameter int RPT_MAX  = 4_999_999,
  parameter int RPT_W    = 25
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  key_filter_multi_if.slave kif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(CNT_MAX);
  localparam logic [RPT_W-1:0] HOLD_LIM = RPT_W'(HOLD_MAX);
  localparam logic [RPT_W-1:0] RPT_LIM  = RPT_W'(RPT_MAX);

  // Synchroniser resets to all-ones so a reset looks like "all released".
  logic [KEY_NUM-1:0] sync_1;
  logic [KEY_NUM-1:0] sync_2;
  logic [KEY_NUM-1:0] key_s;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= kif.key_in;
      sync_2 <= sync_1;
    end
  end

  assign key_s = ~sync_2;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RPT_W-1:0] hold;
    logic             first;     // 1 = next repeat uses the long HOLD period
    logic             level_r;
    logic             flag_r;
`ifdef KEY_FILTER_RELEASE_EN
    logic             rel_r;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state   <= IDLE;
        cnt     <= '0;
        hold    <= '0;
        first   <= 1'b1;
        level_r <= 1'b0;
        flag_r  <= 1'b0;
`ifdef KEY_FILTER_RELEASE_EN
        rel_r   <= 1'b0;
`endif
      end else begin
        flag_r <= 1'b0;
`ifdef KEY_FILTER_RELEASE_EN
        rel_r  <= 1'b0;
`endif
        case (state)
          IDLE: begin
            cnt <= '0;
            if (key_s[i]) state <= PRESS_DB;
          end
          PRESS_DB: begin
            if (!key_s[i]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LIM) begin
              state   <= HELD;
              cnt     <= '0;
              level_r <= 1'b1;
              flag_r  <= 1'b1;
              hold    <= '0;
              first   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          HELD: begin
            if (!key_s[i]) begin
              state <= RELEASE_DB;
              cnt   <= '0;
            end else if (!kif.rpt_en[i]) begin
              hold  <= '0;
              first <= 1'b1;
            end else if (hold == (first ? HOLD_LIM : RPT_LIM)) begin
              flag_r <= 1'b1;
              hold   <= '0;
              first  <= 1'b0;
            end else begin
              hold <= hold + RPT_W'(1);
            end
          end
          RELEASE_DB: begin
            if (key_s[i]) begin
              // Bounce back to pressed: no new flag, repeat restarts from zero.
              state <= HELD;
              cnt   <= '0;
              hold  <= '0;
              first <= 1'b1;
            end else if (cnt == CNT_LIM) begin
              state   <= IDLE;
              cnt     <= '0;
              level_r <= 1'b0;
`ifdef KEY_FILTER_RELEASE_EN
              rel_r   <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign kif.key_level[i] = level_r;
    assign kif.key_flag[i]  = flag_r;
`ifdef KEY_FILTER_RELEASE_EN
    assign kif.key_release[i] = rel_r;
`else
    assign kif.key_release[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi
//   Self-checking bench for key_filter_multi with a short debounce window
//   (CNT_MAX=9), HOLD_MAX=49, RPT_MAX=19. Directed scenarios check the
//   latency / repeat timing rules directly; a randomized run is compared
//   cycle by cycle against a run-length reference model.
module tb_key_filter_multi;
  localparam int K        = 4;
  localparam int CNT_MAX  = 9;
  localparam int CNT_W    = 4;
  localparam int HOLD_MAX = 49;
  localparam int RPT_MAX  = 19;
  localparam int RPT_W    = 6;
  localparam int LAT      = 2 + CNT_MAX + 1 + 1;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  key_filter_multi_if #(.KEY_NUM(K)) kif ();

  key_filter_multi #(
    .KEY_NUM(K), .CNT_MAX(CNT_MAX), .CNT_W(CNT_W),
    .HOLD_MAX(HOLD_MAX), .RPT_MAX(RPT_MAX), .RPT_W(RPT_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .kif      (kif.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a key's debounced level flips once the synchronised
  // key has disagreed with it for CNT_MAX+2 consecutive samples. Repeat
  // pulses come every HOLD_MAX+1 (first) / RPT_MAX+1 (later) undisturbed
  // pressed samples with rpt_en high.
  logic [K-1:0] m_s1, m_s2, m_lvl, m_flag, m_rel;
  int           run [K];
  int           age [K];
  bit           first [K];

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_lvl = '0; m_flag = '0; m_rel = '0;
    for (int i = 0; i < K; i++) begin
      run[i] = 0; age[i] = 0; first[i] = 1'b1;
    end
  endtask

  task automatic model_edge(input logic [K-1:0] kin, input logic [K-1:0] ren);
    logic [K-1:0] ks;
    ks = ~m_s2;
    m_s2 = m_s1;
    m_s1 = kin;
    m_flag = '0;
    m_rel = '0;
    for (int i = 0; i < K; i++) begin
      if (ks[i] != m_lvl[i]) begin
        run[i]++;
        age[i] = 0;
        first[i] = 1'b1;
        if (run[i] == CNT_MAX + 2) begin
          m_lvl[i] = ks[i];
          run[i] = 0;
          if (ks[i]) m_flag[i] = 1'b1;
`ifdef KEY_FILTER_RELEASE_EN
          else m_rel[i] = 1'b1;
`endif
        end
      end else if (run[i] != 0) begin
        run[i] = 0;
      end else if (m_lvl[i] && ren[i]) begin
        age[i]++;
        if (age[i] == (first[i] ? HOLD_MAX + 1 : RPT_MAX + 1)) begin
          m_flag[i] = 1'b1;
          age[i] = 0;
          first[i] = 1'b0;
        end
      end else begin
        age[i] = 0;
        first[i] = 1'b1;
      end
    end
  endtask

  // One clock: model sees the inputs in force at the edge; DUT sampled #1 later.
  task automatic tick();
    model_edge(kif.key_in, kif.rpt_en);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    kif.key_in = '1;
    kif.rpt_en = '0;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++;
    if ({kif.key_level, kif.key_flag, kif.key_release} !== '0) begin
      n_err++;
      $display("FAIL reset_held: got %b expected 0", {kif.key_level, kif.key_flag, kif.key_release});
    end
    sys_rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 100; c++) begin
      tick();
      n_cmp++;
      if ({kif.key_level, kif.key_flag, kif.key_release} !== '0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: got %b expected 0", c,
                 {kif.key_level, kif.key_flag, kif.key_release});
      end
    end
  endtask

  task automatic test_latency();
    int n;
    n = 0;
    kif.key_in[0] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (kif.key_flag[0]) begin n = c; break; end
    end
    n_cmp++;
    if (n != LAT) begin
      n_err++;
      $display("FAIL press_latency: got %0d clocks expected %0d", n, LAT);
    end
    n_cmp++;
    if (kif.key_level !== 4'b0001 || kif.key_flag !== 4'b0001) begin
      n_err++;
      $display("FAIL press_outputs: level %b flag %b expected 0001/0001", kif.key_level, kif.key_flag);
    end
    tick();
    n_cmp++;
    if (kif.key_flag[0] !== 1'b0 || kif.key_level[0] !== 1'b1) begin
      n_err++;
      $display("FAIL flag_single: flag %b level %b expected 0/1", kif.key_flag[0], kif.key_level[0]);
    end
    kif.key_in[0] = 1'b1;
    idle_ticks(30);
  endtask

  task automatic test_bounce();
    int nf, nr, nf2;
    nf = 0; nr = 0; nf2 = 0;
    for (int b = 0; b < 4; b++) begin
      kif.key_in[1] = 1'b0;
      for (int c = 0; c < 5; c++) begin tick(); nf += kif.key_flag[1]; end
      kif.key_in[1] = 1'b1;
      for (int c = 0; c < 3; c++) begin tick(); nf += kif.key_flag[1]; end
    end
    kif.key_in[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin tick(); nf += kif.key_flag[1]; end
    n_cmp++;
    if (nf != 1 || kif.key_level[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_press: flags %0d level %b expected 1/1", nf, kif.key_level[1]);
    end
    for (int b = 0; b < 4; b++) begin
      kif.key_in[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin tick(); nr += kif.key_release[1]; nf2 += kif.key_flag[1]; end
      kif.key_in[1] = 1'b0;
      for (int c = 0; c < 3; c++) begin tick(); nr += kif.key_release[1]; nf2 += kif.key_flag[1]; end
    end
    kif.key_in[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin tick(); nr += kif.key_release[1]; nf2 += kif.key_flag[1]; end
    n_cmp++;
`ifdef KEY_FILTER_RELEASE_EN
    if (nr != 1) begin
      n_err++;
      $display("FAIL bounce_release: releases %0d expected 1", nr);
    end
`else
    if (nr != 0) begin
      n_err++;
      $display("FAIL bounce_release: releases %0d expected 0", nr);
    end
`endif
    n_cmp++;
    if (nf2 != 0 || kif.key_level[1] !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_release_level: flags %0d level %b expected 0/0", nf2, kif.key_level[1]);
    end
  endtask

  task automatic test_repeat();
    int t_q[$];
    int exp_rel[4];
    exp_rel = '{0, 50, 70, 90};
    kif.rpt_en[2] = 1'b1;
    kif.key_in[2] = 1'b0;
    for (int c = 1; c <= LAT + 100; c++) begin
      tick();
      if (kif.key_flag[2]) t_q.push_back(c);
    end
    n_cmp++;
    if (t_q.size() != 4) begin
      n_err++;
      $display("FAIL repeat_count: got %0d flags expected 4", t_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (t_q[j] - t_q[0] != exp_rel[j]) begin
          n_err++;
          $display("FAIL repeat_time[%0d]: got +%0d expected +%0d", j, t_q[j] - t_q[0], exp_rel[j]);
        end
      end
    end
    kif.key_in[2] = 1'b1;
    idle_ticks(30);
    t_q.delete();
    kif.rpt_en[2] = 1'b0;
    kif.key_in[2] = 1'b0;
    for (int c = 1; c <= LAT + 100; c++) begin
      tick();
      if (kif.key_flag[2]) t_q.push_back(c);
    end
    n_cmp++;
    if (t_q.size() != 1) begin
      n_err++;
      $display("FAIL norepeat_count: got %0d flags expected 1", t_q.size());
    end
    kif.key_in[2] = 1'b1;
    idle_ticks(30);
  endtask

  task automatic test_simultaneous();
    logic [K-1:0] seen;
    seen = '0;
    kif.key_in[0] = 1'b0;
    kif.key_in[3] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (kif.key_flag != '0) begin seen = kif.key_flag; break; end
    end
    n_cmp++;
    if (seen !== 4'b1001) begin
      n_err++;
      $display("FAIL simultaneous: flag vector %b expected 1001", seen);
    end
    kif.key_in = '1;
    idle_ticks(30);
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    kif.key_in[1] = 1'b0;
    idle_ticks(8);            // PRESS_DB with cnt = 5
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({kif.key_level, kif.key_flag, kif.key_release} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %b expected 0", {kif.key_level, kif.key_flag, kif.key_release});
    end
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_reset();
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (kif.key_flag[1]) begin n = c; break; end
    end
    n_cmp++;
    if (n != LAT) begin
      n_err++;
      $display("FAIL reset_mid_latency: got %0d clocks expected %0d", n, LAT);
    end
    kif.key_in[1] = 1'b1;
    idle_ticks(30);
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < K; i++) begin
        if ($urandom_range(11) == 0) kif.key_in[i] = ~kif.key_in[i];
        if ($urandom_range(199) == 0) kif.rpt_en[i] = ~kif.rpt_en[i];
      end
      tick();
      n_cmp++;
      if ({kif.key_level, kif.key_flag, kif.key_release} !== {m_lvl, m_flag, m_rel}) begin
        n_err++;
        if (bad < 10)
          $display("FAIL random cycle %0d: lvl/flag/rel %b/%b/%b expected %b/%b/%b", c,
                   kif.key_level, kif.key_flag, kif.key_release, m_lvl, m_flag, m_rel);
        bad++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/key_filter_multi.md
Name: key_filter_multi

Overview:
Parametrised multi-channel debouncer, next generation of the single-key 20 ms filter used in the DDS signal generator front panel. Each of N active-low key inputs is synchronised, debounced over a configurable stable-time window, and produces one-cycle press pulses, optional release pulses, a debounced level, and auto-repeat pulses while held. Sits between the board key pins and the waveform/frequency/phase control logic.

Parameters:
KEY_NUM, 4, number of independent key channels (1..16)
CNT_MAX, 999_999, stable-time window in clocks minus 1 (20 ms at 50 MHz)
CNT_W, 20, width of per-channel debounce counter; must hold CNT_MAX
HOLD_MAX, 24_999_999, clocks of continuous press before first auto-repeat pulse minus 1 (500 ms)
RPT_MAX, 4_999_999, clocks between subsequent auto-repeat pulses minus 1 (100 ms)
RPT_W, 25, width of shared-per-channel hold/repeat counter; must hold HOLD_MAX and RPT_MAX

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  asynchronous active-low reset
key_in  input  KEY_NUM  raw keys, active-low (0 = pressed), asynchronous to sys_clk
rpt_en  input  KEY_NUM  per-channel auto-repeat enable, synchronous
key_level  output  KEY_NUM  debounced state, 1 = pressed
key_flag  output  KEY_NUM  one-cycle pulse on debounced press and on each auto-repeat
key_release  output  KEY_NUM  one-cycle pulse on debounced release

Behaviour:
- One clock sys_clk; reset sys_rst_n asynchronous, active-low. All outputs and state 0 during reset; synchroniser flops reset to 1 (released).
- Input path: 2-flop synchroniser per bit; key_s = inverted second stage (1 = pressed).
- Per-channel FSM, states IDLE, PRESS_DB, HELD, RELEASE_DB:
  - IDLE: key_level=0. key_s=1 -> PRESS_DB, cnt cleared.
  - PRESS_DB: cnt increments each cycle key_s=1; key_s=0 -> IDLE, cnt=0. When cnt==CNT_MAX with key_s=1 -> HELD, key_level<=1, key_flag pulses that same edge, hold counter cleared.
  - HELD: key_s=0 -> RELEASE_DB, cnt=0. Auto-repeat runs only when rpt_en[i]=1: hold counter counts to HOLD_MAX, emits key_flag, reloads; later periods use RPT_MAX. rpt_en low clears hold counter and restarts first-period timing.
  - RELEASE_DB: mirror of PRESS_DB; key_s=1 -> HELD (no new key_flag, repeat timing continues from zero). cnt==CNT_MAX with key_s=0 -> IDLE, key_level<=0, key_release pulses.
- Latency: raw edge to key_flag = 2 (sync) + CNT_MAX+1 + 1 clocks when input clean.
- key_flag, key_release are single-cycle, registered; never both high on one channel in the same cycle.
- Channels fully independent; simultaneous presses yield simultaneous flags.
- Counters saturate never: cleared on every state change; no wrap-around possible since compare to MAX precedes overflow.
- Reset mid-debounce or mid-hold: returns to IDLE, no pulse emitted after deassertion unless full window re-elapses.
- Glitch shorter than window: no output change.

Optional Feature:
Macro KEY_FILTER_RELEASE_EN. Defined: key_release port driven as specified. Not defined: key_release tied to 0, RELEASE_DB still debounces key_level, release pulse logic removed.

Test Plan:
- Reset, all keys high, CNT_MAX=9 -> all outputs 0 for 100 cycles.
- key_in[0] low continuously, CNT_MAX=9 -> key_flag[0] single pulse 13 clocks after edge, key_level[0]=1, other channels 0.
- key_in[1] bounce: 5 low/3 high pulses x4 then stable low -> exactly one key_flag[1]; then bounce on release -> exactly one key_release[1] (macro on), none (macro off).
- Hold key 2 with rpt_en[2]=1, HOLD_MAX=49, RPT_MAX=19 -> flags at press, +50, +70, +90 clocks; rpt_en[2]=0 -> only press flag.
- Keys 0 and 3 pressed on same cycle -> key_flag[0] and key_flag[3] high on the same cycle.
- Assert sys_rst_n low at cnt=5 during PRESS_DB -> outputs 0 immediately; after release key still low -> flag after a full new window.
